// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter
//   Multi-cycle radix-2 restoring divider for DIV (signed) and DIVU (unsigned).
//   It sits in the EX stage next to the ALU. While a divide is pending it holds
//   the front of the pipeline with stall_req. The quotient goes to LO and the
//   remainder goes to HI, and both are handed to the EX/MEM latch with a
//   one-cycle write-enable pulse.
//
//   Operands are reduced to magnitudes. The unsigned quotient and remainder
//   are produced one bit per cycle. The result signs are fixed up when the
//   result is registered: the quotient follows the operand signs and the
//   remainder follows the dividend sign.
//
// Ports
//   clk           in   1           rising-edge clock
//   rst           in   1           synchronous reset, active-high
//   start         in   1           request a divide (sampled only in IDLE)
//   div_signed    in   1           1 = DIV (signed), 0 = DIVU
//   dividend      in   DATA_WIDTH  srcA, captured with start
//   divisor       in   DATA_WIDTH  srcB, captured with start
//   annul         in   1           pipeline flush; aborts an in-flight divide
//   stall_req     out  1           hold IF/ID/EX while a divide is pending
//   result_valid  out  1           one-cycle pulse; hi_out/lo_out are valid
//   we_hi         out  1           HI write enable (same as result_valid)
//   we_lo         out  1           LO write enable (same as result_valid)
//   hi_out        out  DATA_WIDTH  remainder, held until the next result
//   lo_out        out  DATA_WIDTH  quotient, held until the next result
// -----------------------------------------------------------------------------
module div_iter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  div_signed,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic                  annul,
    output logic                  stall_req,
    output logic                  result_valid,
    output logic                  we_hi,
    output logic                  we_lo,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ZERO = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   acc_q, acc_d;      // partial remainder; raw dividend in ZERO
    logic [DATA_WIDTH-1:0]   quo_q, quo_d;      // dividend magnitude shifting into quotient
    logic [DATA_WIDTH-1:0]   dvs_q, dvs_d;      // divisor magnitude
    logic                    sign_q_q, sign_q_d;
    logic                    sign_r_q, sign_r_d;
    logic [DATA_WIDTH-1:0]   hi_q, hi_d;
    logic [DATA_WIDTH-1:0]   lo_q, lo_d;

    // Operand magnitudes, used only on the start cycle.
    logic [DATA_WIDTH-1:0]   dividend_mag;
    logic [DATA_WIDTH-1:0]   divisor_mag;
    logic                    dividend_neg;
    logic                    divisor_neg;

    // One restoring step.
    logic [DATA_WIDTH:0]     acc_sh;            // {acc, q} shifted left, upper half
    logic                    trial_ok;          // acc_sh - |divisor| >= 0
    logic [DATA_WIDTH-1:0]   acc_nxt;
    logic [DATA_WIDTH-1:0]   quo_nxt;

    assign dividend_neg = div_signed & dividend[DATA_WIDTH-1];
    assign divisor_neg  = div_signed & divisor[DATA_WIDTH-1];
    assign dividend_mag = dividend_neg ? (~dividend + 1'b1) : dividend;
    assign divisor_mag  = divisor_neg  ? (~divisor  + 1'b1) : divisor;

    // acc_sh needs one extra bit because the shifted remainder can reach
    // 2*|divisor|-1. When the trial subtraction succeeds, the difference is
    // below |divisor|, so the low DATA_WIDTH bits of the difference are exact.
    assign acc_sh   = {acc_q, quo_q[DATA_WIDTH-1]};
    assign trial_ok = (acc_sh >= {1'b0, dvs_q});
    assign acc_nxt  = trial_ok ? (acc_sh[DATA_WIDTH-1:0] - dvs_q) : acc_sh[DATA_WIDTH-1:0];
    assign quo_nxt  = {quo_q[DATA_WIDTH-2:0], trial_ok};

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        quo_d        = quo_q;
        dvs_d        = dvs_q;
        sign_q_d     = sign_q_q;
        sign_r_d     = sign_r_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        stall_req    = 1'b0;
        result_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The stall is raised in the request cycle so that the
                // instruction stays in EX while the divider works.
                stall_req = start & ~annul;
                if (start && !annul) begin
                    if (divisor == '0) begin
                        acc_d   = dividend;     // raw dividend becomes HI
                        state_d = ZERO;
                    end else begin
                        acc_d    = '0;
                        quo_d    = dividend_mag;
                        dvs_d    = divisor_mag;
                        sign_q_d = div_signed & (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]);
                        sign_r_d = div_signed & dividend[DATA_WIDTH-1];
                        cnt_d    = CNT_W'(DATA_WIDTH);
                        state_d  = BUSY;
                    end
                end
            end

            ZERO: begin
                stall_req = 1'b1;
                if (annul) begin
                    state_d = IDLE;
                end else begin
                    hi_d    = acc_q;
                    lo_d    = '1;
                    state_d = DONE;
                end
            end

            BUSY: begin
                stall_req = 1'b1;
                if (annul) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_nxt;
                    quo_d = quo_nxt;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        // On the last iteration the signed result is taken
                        // straight from this step, so it is already
                        // registered when DONE asserts result_valid.
                        lo_d    = sign_q_q ? (~quo_nxt + 1'b1) : quo_nxt;
                        hi_d    = sign_r_q ? (~acc_nxt + 1'b1) : acc_nxt;
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                // annul is ignored here: the result is already committed.
                result_valid = 1'b1;
                state_d      = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only. Reset is
    // synchronous and also clears the datapath registers, so nothing is left
    // from an aborted divide.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            sign_q_q <= sign_q_d;
            sign_r_q <= sign_r_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign we_hi  = result_valid;
    assign we_lo  = result_valid;
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_div_iter.sv
// -----------------------------------------------------------------------------
// tb_div_iter
//   Directed self-checking bench for div_iter (DATA_WIDTH = 32). Inputs change
//   1 time unit after each rising edge, and outputs are sampled there too.
//   "Cycle N" means N clock edges after the cycle in which start was raised.
// -----------------------------------------------------------------------------
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        annul;
    logic        stall_req;
    logic        result_valid;
    logic        we_hi;
    logic        we_lo;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_cmp  = 0;
    int n_fail = 0;

    div_iter #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .div_signed   (div_signed),
        .dividend     (dividend),
        .divisor      (divisor),
        .annul        (annul),
        .stall_req    (stall_req),
        .result_valid (result_valid),
        .we_hi        (we_hi),
        .we_lo        (we_lo),
        .hi_out       (hi_out),
        .lo_out       (lo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one divide, wait (bounded) for result_valid and check the latency
    // in cycles from the start cycle, the result and the write enables.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi, input int exp_lat);
        int cyc;
        div_signed = sgn;
        dividend   = a;
        divisor    = b;
        start      = 1'b1;
        #1;
        check({tag, " stall@start"}, 32'(stall_req), 32'd1);
        step();
        start = 1'b0;
        cyc   = 1;
        while (!result_valid && cyc < 60) begin
            step();
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " we_hi"},   32'(we_hi), 32'd1);
        check({tag, " we_lo"},   32'(we_lo), 32'd1);
        check({tag, " stall@done"}, 32'(stall_req), 32'd0);
        check({tag, " lo"}, lo_out, exp_lo);
        check({tag, " hi"}, hi_out, exp_hi);
        step();
        check({tag, " valid drops"}, 32'(result_valid), 32'd0);
    endtask

    initial begin
        int cyc;
        int n_rv;
        int rv_cyc;
        logic [31:0] rv_lo;
        logic [31:0] rv_hi;

        rst        = 1'b1;
        start      = 1'b0;
        div_signed = 1'b0;
        dividend   = '0;
        divisor    = '0;
        annul      = 1'b0;
        step();
        step();

        // Reset state.
        check("rst stall", 32'(stall_req), 32'd0);
        check("rst valid", 32'(result_valid), 32'd0);
        check("rst we_hi", 32'(we_hi), 32'd0);
        check("rst we_lo", 32'(we_lo), 32'd0);
        check("rst hi", hi_out, 32'd0);
        check("rst lo", lo_out, 32'd0);
        rst = 1'b0;
        step();

        // DIV 7/2, checked cycle by cycle: stall in cycles 0..32, valid only at 33.
        div_signed = 1'b1;
        dividend   = 32'd7;
        divisor    = 32'd2;
        start      = 1'b1;
        #1;
        check("d7/2 c0 stall", 32'(stall_req), 32'd1);
        check("d7/2 c0 valid", 32'(result_valid), 32'd0);
        for (int c = 1; c <= 32; c++) begin
            step();
            start = 1'b0;
            check($sformatf("d7/2 c%0d stall", c), 32'(stall_req), 32'd1);
            check($sformatf("d7/2 c%0d valid", c), 32'(result_valid), 32'd0);
        end
        step();
        check("d7/2 c33 valid", 32'(result_valid), 32'd1);
        check("d7/2 c33 we_hi", 32'(we_hi), 32'd1);
        check("d7/2 c33 we_lo", 32'(we_lo), 32'd1);
        check("d7/2 c33 stall", 32'(stall_req), 32'd0);
        check("d7/2 lo", lo_out, 32'd3);
        check("d7/2 hi", hi_out, 32'd1);
        step();
        check("d7/2 c34 valid", 32'(result_valid), 32'd0);
        check("d7/2 hold lo", lo_out, 32'd3);
        check("d7/2 hold hi", hi_out, 32'd1);

        // Sign combinations and the signed overflow case.
        run_div("div -7/2",    1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        run_div("div 7/-2",    1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         33);
        run_div("divu ~0/16",  1'b0, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 32'hF,         33);
        run_div("div -1/16",   1'b1, 32'hFFFF_FFFF, 32'h10,        32'd0,         32'hFFFF_FFFF, 33);
        run_div("div ovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         33);
        run_div("div -100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 33);
        run_div("divu big",    1'b0, 32'hFFFF_FFFE, 32'h8000_0000, 32'd1,         32'h7FFF_FFFE, 33);

        // Divide by zero: quotient all-ones, remainder = raw dividend.
        run_div("divu 5/0",    1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         2);
        run_div("div -7/0",    1'b1, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFF9, 2);
        run_div("divu 5/0 b",  1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         2);

        // annul in BUSY at cycle 10: IDLE at 11, prior result held; restart at 12.
        div_signed = 1'b1;
        dividend   = 32'd100;
        divisor    = 32'd7;
        start      = 1'b1;
        step();
        start = 1'b0;
        for (int c = 2; c <= 10; c++) step();
        annul = 1'b1;
        step();
        annul = 1'b0;
        check("annul c11 stall", 32'(stall_req), 32'd0);
        check("annul c11 valid", 32'(result_valid), 32'd0);
        check("annul hold lo", lo_out, 32'hFFFF_FFFF);
        check("annul hold hi", hi_out, 32'd5);
        step();
        div_signed = 1'b0;
        start      = 1'b1;
        cyc        = 12;
        n_rv       = 0;
        rv_cyc     = 0;
        rv_lo      = '0;
        rv_hi      = '0;
        while (cyc < 60) begin
            step();
            start = 1'b0;
            cyc++;
            if (result_valid) begin
                n_rv++;
                if (n_rv == 1) begin
                    rv_cyc = cyc;
                    rv_lo  = lo_out;
                    rv_hi  = hi_out;
                end
            end
        end
        check("annul restart count", 32'(n_rv), 32'd1);
        check("annul restart cycle", 32'(rv_cyc), 32'd45);
        check("annul restart lo", rv_lo, 32'd14);
        check("annul restart hi", rv_hi, 32'd2);

        // annul in IDLE blocks the start in the same cycle.
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        annul    = 1'b1;
        #1;
        check("annul idle stall", 32'(stall_req), 32'd0);
        step();
        start = 1'b0;
        annul = 1'b0;
        n_rv  = 0;
        for (int c = 0; c < 36; c++) begin
            check($sformatf("annul idle stall c%0d", c + 1), 32'(stall_req), 32'd0);
            if (result_valid) n_rv++;
            step();
        end
        check("annul idle no result", 32'(n_rv), 32'd0);

        // annul in ZERO: no result, prior outputs held.
        dividend = 32'd77;
        divisor  = 32'd0;
        start    = 1'b1;
        step();
        start = 1'b0;
        annul = 1'b1;
        step();
        annul = 1'b0;
        check("annul zero valid", 32'(result_valid), 32'd0);
        check("annul zero stall", 32'(stall_req), 32'd0);
        check("annul zero hold hi", hi_out, 32'd2);
        step();
        check("annul zero valid2", 32'(result_valid), 32'd0);

        // rst at cycle 20 of a divide: every output back to zero at 21.
        div_signed = 1'b1;
        dividend   = 32'hFFFF_FF9C;
        divisor    = 32'd7;
        start      = 1'b1;
        step();
        start = 1'b0;
        for (int c = 2; c <= 20; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst c21 stall", 32'(stall_req), 32'd0);
        check("rst c21 valid", 32'(result_valid), 32'd0);
        check("rst c21 hi", hi_out, 32'd0);
        check("rst c21 lo", lo_out, 32'd0);
        n_rv = 0;
        for (int c = 0; c < 20; c++) begin
            if (result_valid) n_rv++;
            step();
        end
        check("rst no late result", 32'(n_rv), 32'd0);

        // start pulses during BUSY are ignored: one result, from the first operands.
        div_signed = 1'b0;
        dividend   = 32'd1000;
        divisor    = 32'd3;
        start      = 1'b1;
        cyc        = 0;
        n_rv       = 0;
        rv_cyc     = 0;
        rv_lo      = '0;
        rv_hi      = '0;
        while (cyc < 60) begin
            step();
            cyc++;
            start = (cyc == 5) || (cyc == 20);
            if (cyc == 5) begin
                dividend = 32'd9;
                divisor  = 32'd0;
            end
            if (result_valid) begin
                n_rv++;
                if (n_rv == 1) begin
                    rv_cyc = cyc;
                    rv_lo  = lo_out;
                    rv_hi  = hi_out;
                end
            end
        end
        check("busy start count", 32'(n_rv), 32'd1);
        check("busy start cycle", 32'(rv_cyc), 32'd33);
        check("busy start lo", rv_lo, 32'd333);
        check("busy start hi", rv_hi, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
